// File: rtl/uart_hex_display.sv
// Shifts received bytes into a DIGITS-nibble hex buffer and scans it onto a multiplexed 7-segment display.
// Optional leading-zero blanking is enabled with `define UART_HEX_DISPLAY_LZ_BLANK_EN.
module uart_hex_display #(
   parameter int DIGITS          = 4,
   parameter int DWELL_CYCLES    = 25000,
   parameter int SEG_ACTIVE_HIGH = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        rx_data,
   input  logic              rx_ready,
   input  logic              clr,
   input  logic              hold,
   input  logic [2:0]        bright,
   output logic [6:0]        seg,
   output logic [DIGITS-1:0] dsen
);

   localparam int CW       = $clog2(DWELL_CYCLES);
   localparam int IW       = $clog2(DIGITS);
   localparam int SLOT_LEN = DWELL_CYCLES / 8;
   localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_HIGH != 0) ? 7'h00 : 7'h7F;

   logic [DIGITS-1:0][3:0] r_buf;
   logic [CW-1:0]          r_cnt;
   logic [IW-1:0]          r_idx;
   logic [6:0]             r_seg;
   logic [DIGITS-1:0]      r_dsen;

   logic [2:0]             w_slot;
   logic                   w_blank;
   logic                   w_en;
   logic [3:0]             w_nib;
   logic [6:0]             w_seg_nxt;
   logic [DIGITS-1:0]      w_dsen_nxt;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'h3F;
         4'h1: hex7 = 7'h06;
         4'h2: hex7 = 7'h5B;
         4'h3: hex7 = 7'h4F;
         4'h4: hex7 = 7'h66;
         4'h5: hex7 = 7'h6D;
         4'h6: hex7 = 7'h7D;
         4'h7: hex7 = 7'h07;
         4'h8: hex7 = 7'h7F;
         4'h9: hex7 = 7'h6F;
         4'hA: hex7 = 7'h77;
         4'hB: hex7 = 7'h7C;
         4'hC: hex7 = 7'h39;
         4'hD: hex7 = 7'h5E;
         4'hE: hex7 = 7'h79;
         default: hex7 = 7'h71;
      endcase
   endfunction

   // Handshake: no back-pressure. Every cycle rx_ready is high, rx_data is a
   // complete byte and causes exactly one two-nibble shift (unless clr/hold).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_buf <= '0;
      end else if (clr) begin
         r_buf <= '0;
      end else if (!hold && rx_ready) begin
         for (int k = DIGITS - 1; k >= 2; k--) begin
            r_buf[k] <= r_buf[k-2];
         end
         r_buf[1] <= rx_data[7:4];
         r_buf[0] <= rx_data[3:0];
      end
   end

   // Scan timing is free-running and never disturbed by rx, clr or hold.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
         r_idx <= '0;
      end else if (r_cnt == CW'(DWELL_CYCLES - 1)) begin
         r_cnt <= '0;
         r_idx <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   always_comb begin
      w_slot  = 3'(r_cnt / CW'(SLOT_LEN));
      w_nib   = r_buf[r_idx];
      w_blank = 1'b0;
`ifdef UART_HEX_DISPLAY_LZ_BLANK_EN
      // Blank the selected digit when it and every digit above it are zero.
      w_blank = (r_idx != '0);
      for (int k = 0; k < DIGITS; k++) begin
         if ((IW'(k) >= r_idx) && (r_buf[k] != 4'h0)) begin
            w_blank = 1'b0;
         end
      end
`endif
      w_en       = (w_slot <= bright) && !w_blank;
      w_dsen_nxt = '1;
      if (w_en) begin
         w_dsen_nxt[r_idx] = 1'b0;
      end
      w_seg_nxt = (SEG_ACTIVE_HIGH != 0) ? hex7(w_nib) : ~hex7(w_nib);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_seg  <= SEG_OFF;
         r_dsen <= '1;
      end else begin
         r_seg  <= w_seg_nxt;
         r_dsen <= w_dsen_nxt;
      end
   end

   assign seg  = r_seg;
   assign dsen = r_dsen;

endmodule

// File: doc/uart_hex_display.md
Name: uart_hex_display

Overview:
- Parametrised successor to the fixed 4-digit receive-byte display path.
- Accepts a byte stream from uart_rx using the rx_data/rx_ready pulse handshake, and shifts the bytes into an N-digit hex nibble buffer.
- Time-multiplexes the buffer onto a common 7-segment bus with active-low digit enables.
- Adds 8-level PWM brightness, synchronous clear and hold.

Parameters:
- DIGITS, 4, number of digits, legal 2..8, must be even.
- DWELL_CYCLES, 25000, clk cycles each digit is selected; must be a multiple of 8 and ≥8.
- SEG_ACTIVE_HIGH, 1, 1 = segment lit when bit is 1; 0 = inverted segment outputs.

Ports:
- clk  in  1  system clock (50 MHz on board)
- reset  in  1  asynchronous, active-low reset
- rx_data  in  8  received byte
- rx_ready  in  1  one-cycle strobe, rx_data valid this cycle
- clr  in  1  synchronous clear of digit buffer
- hold  in  1  freeze buffer; incoming bytes discarded
- bright  in  3  brightness, on-time = (bright+1)/8 of dwell
- seg  out  7  segments a..g, bit0=a … bit6=g
- dsen  out  DIGITS  digit enables, active-low, bit0 = rightmost digit

Behaviour:
- Reset (reset=0, async):
  - buffer all nibbles = 0; cnt = 0; idx = 0.
  - dsen = all 1; seg = all unlit (0 if SEG_ACTIVE_HIGH, else 7'h7F).
  - Takes effect immediately, mid-scan or mid-byte; no partial state survives.
- Buffer update, evaluated on each rising clk, priority order:
  1. clr=1: all nibbles set to 0. Any rx_ready that cycle is discarded. clr overrides hold.
  2. hold=1: buffer unchanged; rx_ready ignored, and the byte is not stored later.
  3. rx_ready=1: buffer shifts up by two nibbles (digit k ← digit k-2), digit1 ← rx_data[7:4], digit0 ← rx_data[3:0]. Top two nibbles are lost.
- Each byte causes exactly one shift. rx_ready held high for M cycles gives M shifts; this is not the expected source behaviour, but it is defined.
- Scan counters:
  - cnt runs 0..DWELL_CYCLES-1, then wraps to 0.
  - When cnt = DWELL_CYCLES-1, idx advances (DIGITS-1 wraps to 0).
  - slot = cnt / (DWELL_CYCLES/8), range 0..7.
- Outputs are registered and lag the counters and buffer by 1 cycle:
  - dsen[idx] = 0 iff slot ≤ bright (and not blanked, see optional feature). All other dsen bits = 1.
  - seg = hex decode of buffer[idx] (inverted when SEG_ACTIVE_HIGH=0).
- Only one dsen bit may ever be 0. dsen and seg change on the same edge.
- Hex decode, bit6..bit0 = g..a, active-high:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- bright=7: digit enabled for all DWELL_CYCLES. bright=0: enabled for the first DWELL_CYCLES/8 cycles only.
- A bright change takes effect at the next cycle's comparison; no glitch protection is required.
- Latency: a byte strobed in cycle t is in the buffer after edge t+1. It appears on seg at the first registered output for that digit after that.
- Scan timing is independent of rx activity, clr and hold.

Optional Feature:
- Macro: UART_HEX_DISPLAY_LZ_BLANK_EN.
- Defined: leading-zero blanking.
  - Digit k is blanked (dsen[k] held 1) when nibbles k..DIGITS-1 are all zero and k>0.
  - Digit 0 is never blanked.
  - Blanking is evaluated from the same buffer snapshot used for that output cycle.
- Undefined: all digits display, including leading zeros. Logic is absent.

Test Plan:
Bench parameters: DIGITS=4, DWELL_CYCLES=16, SEG_ACTIVE_HIGH=1.
- Reset: release reset, no input → dsen=4'b1111 then the scan begins. seg=7'h3F whenever any dsen bit=0. dsen[0] is low for cycles 1..16 at bright=7, then dsen[1], with 1-cycle output lag.
- Bytes: strobe 0x12 then 0xAB → buffer digits3..0 = 1,2,A,B. During idx=0 seg=7C, idx=1 seg=77, idx=2 seg=5B, idx=3 seg=06.
- Hold, then clr: hold=1, strobe 0xFF → buffer unchanged. clr=1 together with rx_ready carrying 0x55 → all digits show 3F; 0x55 is never stored.
- Brightness: bright=1 → each dsen bit low for exactly 4 consecutive cycles per 16-cycle dwell. bright=7 → low for 16.
- Reset mid-scan: assert reset at idx=2, cnt=9 → dsen=1111 asynchronously, buffer=0. After release, scan restarts at digit 0, cnt 0.
- With UART_HEX_DISPLAY_LZ_BLANK_EN, strobe 0x05 → dsen[3:1] stay 1 throughout. dsen[0] is active with seg=6D. Then strobe 0x10 (buffer 0,5,1,0) → digits 0..2 active, digit 3 blanked.
